// File: rtl/udma_rx_dp_out_mchan_chkr_pkg.sv
// Shared types and constants for the multi-channel RX data-path-out checker.
package udma_rx_dp_out_mchan_chkr_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } ch_state_e;

    typedef enum logic [1:0] {
        ERR_DROP    = 2'd0,
        ERR_STABLE  = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_SIZE    = 2'd3
    } err_code_e;

    localparam int unsigned ERR_N       = 4;
    localparam int unsigned BIT_DROP    = 0;
    localparam int unsigned BIT_STABLE  = 1;
    localparam int unsigned BIT_TIMEOUT = 2;
    localparam int unsigned BIT_SIZE    = 3;

    localparam logic [1:0] SIZE_RSVD = 2'b11;

    // Highest-priority error code among a set of same-cycle detections
    function automatic err_code_e pick_code(input logic [ERR_N-1:0] det);
        if (det[BIT_DROP]) begin
            return ERR_DROP;
        end else if (det[BIT_STABLE]) begin
            return ERR_STABLE;
        end else if (det[BIT_TIMEOUT]) begin
            return ERR_TIMEOUT;
        end
        return ERR_SIZE;
    endfunction

endpackage

// File: rtl/udma_rx_dp_out_ch_chkr.sv
// Single-channel valid/ready protocol checker with sticky errors and transfer count.
module udma_rx_dp_out_ch_chkr
    import udma_rx_dp_out_mchan_chkr_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clr,
    input  logic              valid,
    input  logic              ready,
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        size,
    output logic [ERR_N-1:0]  det_c,
    output logic              err_pulse,
    output logic [ERR_N-1:0]  err_sticky,
    output logic [CNT_W-1:0]  xfer_cnt
);

    // Wide enough to hold TIMEOUT so the equality compare can hit it
    localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    ch_state_e          state_q;
    ch_state_e          state_d;
    logic [DATA_W-1:0]  lat_data;
    logic [1:0]         lat_size;
    logic [WAIT_W-1:0]  wait_q;
    logic [WAIT_W-1:0]  wait_d;
    logic               lat_ld;
    logic               xfer_c;

    // Next state, detections, wait-counter update and completion strobe
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        lat_ld  = 1'b0;
        xfer_c  = 1'b0;
        det_c   = '0;
        if (enable) begin
            xfer_c = valid & ready;
            if (valid && (size == SIZE_RSVD)) begin
                det_c[BIT_SIZE] = 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (valid && !ready) begin
                        state_d = ST_PEND;
                        lat_ld  = 1'b1;
                        wait_d  = '0;
                    end
                end
                ST_PEND: begin
                    wait_d = (wait_q == '1) ? wait_q : wait_q + WAIT_W'(1);
                    // Fires on the step that reaches TIMEOUT, never while parked there
                    if ((TIMEOUT != 0) && (wait_d == WAIT_W'(TIMEOUT))
                        && (wait_q != WAIT_W'(TIMEOUT))) begin
                        det_c[BIT_TIMEOUT] = 1'b1;
                    end
                    if (!valid) begin
                        det_c[BIT_DROP] = 1'b1;
                        state_d         = ST_IDLE;
                    end else begin
                        if ((data != lat_data) || (size != lat_size)) begin
                            det_c[BIT_STABLE] = 1'b1;
                        end
                        if (ready) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = ST_IDLE;
        end
    end

    // State, latched beat, error strobe, sticky bits and completion counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wait_q     <= '0;
            lat_data   <= '0;
            lat_size   <= '0;
            err_pulse  <= 1'b0;
            err_sticky <= '0;
            xfer_cnt   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            err_pulse <= |det_c;
            if (lat_ld) begin
                lat_data <= data;
                lat_size <= size;
            end
            if (enable) begin
                if (clr) begin
                    err_sticky <= det_c;
                    xfer_cnt   <= '0;
                end else begin
                    err_sticky <= err_sticky | det_c;
                    if (xfer_c && (xfer_cnt != '1)) begin
                        xfer_cnt <= xfer_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/udma_rx_dp_out_mchan_chkr.sv
// Multi-channel RX data-path-out checker: per-channel checkers plus first-error capture.
module udma_rx_dp_out_mchan_chkr
    import udma_rx_dp_out_mchan_chkr_pkg::*;
#(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     clr,
    input  logic [N_CH-1:0]          valid,
    input  logic [N_CH-1:0]          ready,
    input  logic [N_CH*DATA_W-1:0]   data,
    input  logic [N_CH*2-1:0]        size,
    output logic [N_CH-1:0]          err_pulse,
    output logic [N_CH*ERR_N-1:0]    err_sticky,
    output logic                     first_vld,
    output logic [3:0]               first_ch,
    output logic [1:0]               first_code,
    output logic [N_CH*CNT_W-1:0]    xfer_cnt
);

    logic [ERR_N-1:0] det_c [N_CH];
    logic             any_det;
    logic [3:0]       sel_ch;
    err_code_e        sel_code;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        udma_rx_dp_out_ch_chkr #(
            .DATA_W  (DATA_W),
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .enable     (enable),
            .clr        (clr),
            .valid      (valid[c]),
            .ready      (ready[c]),
            .data       (data[c*DATA_W +: DATA_W]),
            .size       (size[c*2 +: 2]),
            .det_c      (det_c[c]),
            .err_pulse  (err_pulse[c]),
            .err_sticky (err_sticky[c*ERR_N +: ERR_N]),
            .xfer_cnt   (xfer_cnt[c*CNT_W +: CNT_W])
        );
    end

    // Lowest-index channel with any detection wins; code by per-channel priority
    always_comb begin
        any_det  = 1'b0;
        sel_ch   = '0;
        sel_code = ERR_DROP;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (!any_det && (det_c[c] != '0)) begin
                any_det  = 1'b1;
                sel_ch   = 4'(c);
                sel_code = pick_code(det_c[c]);
            end
        end
    end

    // First-error capture; clr reloads from any coincident detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_vld  <= 1'b0;
            first_ch   <= '0;
            first_code <= '0;
        end else if (enable) begin
            if (clr) begin
                first_vld  <= any_det;
                first_ch   <= any_det ? sel_ch : 4'd0;
                first_code <= any_det ? sel_code : 2'd0;
            end else if (!first_vld && any_det) begin
                first_vld  <= 1'b1;
                first_ch   <= sel_ch;
                first_code <= sel_code;
            end
        end
    end

endmodule

// File: tb/tb_udma_rx_dp_out_mchan_chkr.sv
// Bench for the multi-channel RX checker: directed scenarios then randomized traffic vs. a model.
module tb_udma_rx_dp_out_mchan_chkr;

    localparam int unsigned N_CH    = 4;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CNT_W   = 4;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   enable = 1'b0;
    logic                   clr = 1'b0;
    logic [N_CH-1:0]        valid = '0;
    logic [N_CH-1:0]        ready = '0;
    logic [N_CH*DATA_W-1:0] data = '0;
    logic [N_CH*2-1:0]      size = '0;
    logic [N_CH-1:0]        err_pulse;
    logic [N_CH*4-1:0]      err_sticky;
    logic                   first_vld;
    logic [3:0]             first_ch;
    logic [1:0]             first_code;
    logic [N_CH*CNT_W-1:0]  xfer_cnt;

    always #5 clk = ~clk;

    udma_rx_dp_out_mchan_chkr #(
        .N_CH    (N_CH),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .clr        (clr),
        .valid      (valid),
        .ready      (ready),
        .data       (data),
        .size       (size),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .first_vld  (first_vld),
        .first_ch   (first_ch),
        .first_code (first_code),
        .xfer_cnt   (xfer_cnt)
    );

    // Reference model: per-channel pending flag, held beat and stall count
    bit                m_pend  [N_CH];
    logic [DATA_W-1:0] m_ldata [N_CH];
    logic [1:0]        m_lsize [N_CH];
    int                m_wait  [N_CH];
    int                e_cnt   [N_CH];
    logic [N_CH-1:0]   e_pulse;
    logic [N_CH*4-1:0] e_sticky;
    logic              e_fv;
    logic [3:0]        e_fch;
    logic [1:0]        e_fcode;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_pend[c]  = 1'b0;
            m_ldata[c] = '0;
            m_lsize[c] = '0;
            m_wait[c]  = 0;
            e_cnt[c]   = 0;
        end
        e_pulse  = '0;
        e_sticky = '0;
        e_fv     = 1'b0;
        e_fch    = '0;
        e_fcode  = '0;
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        logic [3:0] det [N_CH];
        bit         any;
        logic [3:0] fch;
        logic [1:0] fcode;
        any   = 1'b0;
        fch   = '0;
        fcode = '0;
        for (int c = 0; c < N_CH; c++) begin
            logic              v;
            logic              r;
            logic [DATA_W-1:0] d;
            logic [1:0]        s;
            v = valid[c];
            r = ready[c];
            d = data[c*DATA_W +: DATA_W];
            s = size[c*2 +: 2];
            det[c] = 4'b0000;
            if (!enable) begin
                m_pend[c] = 1'b0;
            end else begin
                if (v && s == 2'b11) det[c][3] = 1'b1;
                if (m_pend[c]) begin
                    m_wait[c] = m_wait[c] + 1;
                    if (TIMEOUT != 0 && m_wait[c] == int'(TIMEOUT)) det[c][2] = 1'b1;
                    if (!v) begin
                        det[c][0] = 1'b1;
                        m_pend[c] = 1'b0;
                    end else begin
                        if (d !== m_ldata[c] || s !== m_lsize[c]) det[c][1] = 1'b1;
                        if (r) m_pend[c] = 1'b0;
                    end
                end else if (v && !r) begin
                    m_pend[c]  = 1'b1;
                    m_ldata[c] = d;
                    m_lsize[c] = s;
                    m_wait[c]  = 0;
                end
                if (clr) begin
                    e_sticky[c*4 +: 4] = det[c];
                    e_cnt[c] = 0;
                end else begin
                    e_sticky[c*4 +: 4] = e_sticky[c*4 +: 4] | det[c];
                    if (v && r && e_cnt[c] < (1 << CNT_W) - 1) e_cnt[c] = e_cnt[c] + 1;
                end
            end
            e_pulse[c] = (det[c] != 4'b0000);
            if (!any && det[c] != 4'b0000) begin
                any = 1'b1;
                fch = 4'(c);
                for (int b = 3; b >= 0; b--) if (det[c][b]) fcode = 2'(b);
            end
        end
        if (enable) begin
            if (clr) begin
                e_fv    = any;
                e_fch   = fch;
                e_fcode = fcode;
            end else if (!e_fv && any) begin
                e_fv    = 1'b1;
                e_fch   = fch;
                e_fcode = fcode;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        logic [N_CH*CNT_W-1:0] ecnt;
        for (int c = 0; c < N_CH; c++) ecnt[c*CNT_W +: CNT_W] = CNT_W'(e_cnt[c]);
        check({tag, ".err_pulse"},  64'(err_pulse),  64'(e_pulse));
        check({tag, ".err_sticky"}, 64'(err_sticky), 64'(e_sticky));
        check({tag, ".first_vld"},  64'(first_vld),  64'(e_fv));
        check({tag, ".first_ch"},   64'(first_ch),   64'(e_fv ? e_fch : 4'd0));
        check({tag, ".first_code"}, 64'(first_code), 64'(e_fv ? e_fcode : 2'd0));
        check({tag, ".xfer_cnt"},   64'(xfer_cnt),   64'(ecnt));
    endtask

    // Inputs are applied while clk is low; sample #1 after the rising edge
    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_all(tag);
        @(negedge clk);
    endtask

    task automatic set_ch(input int c, input logic v, input logic r,
                          input logic [DATA_W-1:0] d, input logic [1:0] s);
        valid[c] = v;
        ready[c] = r;
        data[c*DATA_W +: DATA_W] = d;
        size[c*2 +: 2] = s;
    endtask

    task automatic idle_all();
        valid = '0;
        ready = '0;
        clr   = 1'b0;
    endtask

    initial begin
        int pulses;
        int at;
        model_reset();
        #2;
        compare_all("reset");
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        enable = 1'b1;

        // Clean handshake after a three-cycle stall
        set_ch(0, 1'b1, 1'b0, 32'h0000_1234, 2'b10);
        repeat (3) cycle("t036_stall");
        ready[0] = 1'b1;
        cycle("t036_done");
        check("t036_no_pulse", 64'(err_pulse), 64'd0);
        check("t036_cnt0", 64'(xfer_cnt[CNT_W-1:0]), 64'd1);
        idle_all();
        cycle("t036_idle");

        // Data changes while pending on ch1
        set_ch(1, 1'b1, 1'b0, 32'h0000_00A5, 2'b10);
        cycle("t037_enter");
        data[1*DATA_W +: DATA_W] = 32'h0000_005A;
        cycle("t037_change");
        check("t037_pulse1", 64'(err_pulse[1]), 64'd1);
        check("t037_sticky1", 64'(err_sticky[7:4]), 64'h2);
        check("t037_first_ch", 64'(first_ch), 64'd1);
        check("t037_first_code", 64'(first_code), 64'd1);
        ready[1] = 1'b1;
        cycle("t037_done");
        idle_all();
        clr = 1'b1;
        cycle("t037_clr");
        clr = 1'b0;
        check("t037_clr_fv", 64'(first_vld), 64'd0);

        // Long stall on ch2 flags TIMEOUT exactly once
        set_ch(2, 1'b1, 1'b0, 32'hCAFE_0002, 2'b01);
        pulses = 0;
        at = -1;
        for (int i = 0; i < 10; i++) begin
            cycle("t038_stall");
            if (err_pulse[2]) begin
                pulses++;
                at = i;
            end
        end
        check("t038_pulses", 64'(pulses), 64'd1);
        check("t038_at", 64'(at), 64'd4);
        ready[2] = 1'b1;
        cycle("t038_done");
        check("t038_sticky2", 64'(err_sticky[11:8]), 64'h4);
        idle_all();
        clr = 1'b1;
        cycle("t038_clr");
        clr = 1'b0;

        // DROP on ch0 and reserved size on ch3 in the same cycle
        set_ch(0, 1'b1, 1'b0, 32'h0000_0077, 2'b00);
        cycle("t039_enter");
        valid[0] = 1'b0;
        set_ch(3, 1'b1, 1'b1, 32'h0000_0033, 2'b11);
        cycle("t039_both");
        check("t039_pulses", 64'(err_pulse), 64'h9);
        check("t039_first_ch", 64'(first_ch), 64'd0);
        check("t039_first_code", 64'(first_code), 64'd0);
        idle_all();
        clr = 1'b1;
        cycle("t039_clr");
        clr = 1'b0;

        // clr coincident with a DROP on ch1 keeps the new error
        set_ch(1, 1'b1, 1'b0, 32'h0000_0011, 2'b00);
        cycle("t040_enter");
        valid[1] = 1'b0;
        clr = 1'b1;
        cycle("t040_clr_drop");
        clr = 1'b0;
        check("t040_sticky", 64'(err_sticky), 64'h0010);
        check("t040_first_vld", 64'(first_vld), 64'd1);
        check("t040_first_ch", 64'(first_ch), 64'd1);
        check("t040_cnt", 64'(xfer_cnt), 64'd0);

        // Asynchronous reset while ch0 is pending
        set_ch(0, 1'b1, 1'b0, 32'h0000_0099, 2'b01);
        cycle("t041_enter");
        reset = 1'b1;
        #1;
        check("t041_rst_pulse", 64'(err_pulse), 64'd0);
        check("t041_rst_sticky", 64'(err_sticky), 64'd0);
        check("t041_rst_fv", 64'(first_vld), 64'd0);
        check("t041_rst_cnt", 64'(xfer_cnt), 64'd0);
        model_reset();
        @(negedge clk);
        idle_all();
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            cycle("t041_after");
            if (err_pulse != '0) pulses++;
        end
        check("t041_no_err", 64'(pulses), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            enable = ($urandom_range(0, 39) != 0);
            clr    = ($urandom_range(0, 49) == 0);
            for (int c = 0; c < N_CH; c++) begin
                valid[c] = ($urandom_range(0, 9) < 7);
                ready[c] = ($urandom_range(0, 9) < 4);
                if ($urandom_range(0, 7) == 0) data[c*DATA_W +: DATA_W] = $urandom;
                if ($urandom_range(0, 15) == 0) size[c*2 +: 2] = 2'($urandom_range(0, 3));
            end
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
